note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/musicbox_pkg.sv | 22 ++
 rtl/note_sequencer_if.sv | 26 ++
 rtl/slot_timer.sv | 29 ++
 rtl/note_sequencer.sv | 112 +++++++++++
 tb/tb_note_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/musicbox_pkg.sv
// Shared types and defaults for the music-box note sequencer.
// Holds the FSM state enum, song-length and tick-divider defaults, and an address helper.
package musicbox_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StPause,
        StDone
    } seq_state_e;

    localparam int unsigned DefTickDiv  = 12500000;
    localparam int unsigned DefSong0Len = 196;
    localparam int unsigned DefSong1Len = 243;
    localparam int unsigned AddrWidth   = 8;

    // Address of the final slot of a song with the given slot count.
    function automatic logic [AddrWidth-1:0] last_addr(input int unsigned len);
        return AddrWidth'(len - 1);
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control and note-address bundle between a player front-end and the note sequencer.
// The master drives the one-cycle command pulses; the slave (sequencer) drives the ROM side.
interface note_sequencer_if;
    import musicbox_pkg::*;

    logic                 play;
    logic                 pause_tgl;
    logic                 stop;
    logic                 song_sel;
    logic [AddrWidth-1:0] address;
    logic                 song_id;
    logic                 beat_stb;
    logic                 mute;
    logic                 done;

    modport master (
        output play, pause_tgl, stop, song_sel,
        input  address, song_id, beat_stb, mute, done
    );

    modport slave (
        input  play, pause_tgl, stop, song_sel,
        output address, song_id, beat_stb, mute, done
    );

endinterface

// File: rtl/slot_timer.sv
// Note-slot divider: counts 0..TICK_DIV-1 while enabled, with a terminal-count pulse.
// Clear wins over enable; the count holds when enable is low.
module slot_timer import musicbox_pkg::*; #(
    parameter int unsigned TICK_DIV = DefTickDiv
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int unsigned          TickWidth = $clog2(TICK_DIV);
    localparam logic [TickWidth-1:0] TickLast  = TickWidth'(TICK_DIV - 1);

    logic [TickWidth-1:0] tick_q;

    // Combinational so the sequencer can register its address update on this same edge.
    assign wrap = en && (tick_q == TickLast);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            tick_q <= '0;
        end else if (en) begin
            tick_q <= wrap ? '0 : tick_q + TickWidth'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: steps a note-ROM address through the latched song, one slot per TICK_DIV clocks.
// Define SEQ_LOOP_EN to wrap the song forever instead of finishing in DONE.
module note_sequencer import musicbox_pkg::*; #(
    parameter int unsigned TICK_DIV  = DefTickDiv,
    parameter int unsigned SONG0_LEN = DefSong0Len,
    parameter int unsigned SONG1_LEN = DefSong1Len
) (
    input logic             clk,
    input logic             rst_n,
    note_sequencer_if.slave bus
);

    seq_state_e           state_q;
    logic [AddrWidth-1:0] address_q;
    logic                 song_id_q;
    logic                 beat_q;
    logic                 mute_q;
    logic                 done_q;

    logic                 start;
    logic                 timer_en;
    logic                 timer_clr;
    logic                 wrap;
    logic [AddrWidth-1:0] last;

    always_comb begin
        start     = bus.play && ((state_q == StIdle) || (state_q == StDone));
        // play outranks pause_tgl, so play+pause_tgl together in PLAY leaves the count running.
        timer_en  = (state_q == StPlay) && !bus.stop && (bus.play || !bus.pause_tgl);
        timer_clr = bus.stop || start;
        last      = song_id_q ? last_addr(SONG1_LEN) : last_addr(SONG0_LEN);
    end

    slot_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (timer_en),
        .clr   (timer_clr),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            address_q <= '0;
            song_id_q <= 1'b0;
            beat_q    <= 1'b0;
            mute_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            beat_q <= 1'b0;
            if (bus.stop) begin
                state_q   <= StIdle;
                address_q <= '0;
                mute_q    <= 1'b1;
                done_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (bus.play) begin
                            state_q   <= StPlay;
                            song_id_q <= bus.song_sel;
                            address_q <= '0;
                            mute_q    <= 1'b0;
                            done_q    <= 1'b0;
                        end
                    end
                    StPlay: begin
                        if (!bus.play && bus.pause_tgl) begin
                            state_q <= StPause;
                            mute_q  <= 1'b1;
                        end else if (wrap) begin
                            if (address_q == last) begin
`ifdef SEQ_LOOP_EN
                                address_q <= '0;
                                beat_q    <= 1'b1;
`else
                                state_q <= StDone;
                                mute_q  <= 1'b1;
                                done_q  <= 1'b1;
`endif
                            end else begin
                                address_q <= address_q + AddrWidth'(1);
                                beat_q    <= 1'b1;
                            end
                        end
                    end
                    StPause: begin
                        if (bus.play || bus.pause_tgl) begin
                            state_q <= StPlay;
                            mute_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        mute_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.address  = address_q;
    assign bus.song_id  = song_id_q;
    assign bus.beat_stb = beat_q;
    assign bus.mute     = mute_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with TICK_DIV=4, SONG0_LEN=5, SONG1_LEN=7.
// Stimulus pushes expected beat/done events; a negedge monitor pops and compares them.
module tb_note_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    note_sequencer_if bus ();

    note_sequencer #(
        .TICK_DIV  (4),
        .SONG0_LEN (5),
        .SONG1_LEN (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit is_done;
        int addr;
        bit song;
        int gap;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_beat = 0;
    bit   done_prev = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic push_beat(input int addr, input bit song, input int gap);
        exp_t e;
        e.is_done = 1'b0; e.addr = addr; e.song = song; e.gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic push_done(input int addr, input bit song);
        exp_t e;
        e.is_done = 1'b1; e.addr = addr; e.song = song; e.gap = 0;
        sb_q.push_back(e);
    endtask

    // Monitor: every beat_stb pulse and every rising edge of done is one scoreboard event.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.beat_stb === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got beat at addr %0d, want none", bus.address);
            end else begin
                e = sb_q.pop_front();
                if (e.is_done || bus.address != e.addr[7:0] || bus.song_id != e.song ||
                    (e.gap != 0 && cyc - last_beat != e.gap)) begin
                    errors++;
                    $display("FAIL beat: got addr=%0d song=%0d gap=%0d, want done=%0d addr=%0d song=%0d gap=%0d",
                             bus.address, bus.song_id, cyc - last_beat, e.is_done, e.addr, e.song,
                             e.gap);
                end
            end
            last_beat = cyc;
        end
        if (bus.done === 1'b1 && !done_prev) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done at addr %0d, want none", bus.address);
            end else begin
                e = sb_q.pop_front();
                if (!e.is_done || bus.address != e.addr[7:0] || bus.song_id != e.song ||
                    bus.mute !== 1'b1) begin
                    errors++;
                    $display("FAIL done_event: got addr=%0d song=%0d mute=%0d, want done=%0d addr=%0d song=%0d mute=1",
                             bus.address, bus.song_id, bus.mute, e.is_done, e.addr, e.song);
                end
            end
        end
        done_prev = (bus.done === 1'b1);
    end

    // Callers sit on a negedge; the pulse is sampled by the following posedge.
    task automatic pulse_play(input logic sel);
        bus.song_sel = sel;
        bus.play = 1'b1;
        @(negedge clk);
        bus.play = 1'b0;
    endtask

    task automatic pulse_pause();
        bus.pause_tgl = 1'b1;
        @(negedge clk);
        bus.pause_tgl = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        bus.play = 1'b0;
        bus.pause_tgl = 1'b0;
        bus.stop = 1'b0;
        bus.song_sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_address", bus.address, 0);
        check("rst_song_id", bus.song_id, 0);
        check("rst_beat", bus.beat_stb, 0);
        check("rst_mute", bus.mute, 1);
        check("rst_done", bus.done, 0);
        rst_n = 1'b1;

`ifdef SEQ_LOOP_EN
        // Three full passes 1,2,3,4,0 with no DONE.
        for (int i = 0; i < 15; i++) push_beat((i + 1) % 5, 1'b0, (i == 0) ? 0 : 4);
        pulse_play(1'b0);
        for (int i = 0; i < 60; i++) begin
            check("loop_done_low", bus.done, 0);
            @(negedge clk);
        end
        check("loop_mute", bus.mute, 0);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("loop_stop_addr", bus.address, 0);
        check("loop_stop_mute", bus.mute, 1);
        repeat (8) @(negedge clk);
`else
        // Song 0 start to finish.
        for (int a = 1; a <= 4; a++) push_beat(a, 1'b0, (a == 1) ? 0 : 4);
        push_done(4, 1'b0);
        pulse_play(1'b0);
        check("s0_start_addr", bus.address, 0);
        check("s0_start_mute", bus.mute, 0);
        wait_done(40, n);
        check("s0_done_cycles", n, 20);
        check("s0_done_mute", bus.mute, 1);
        repeat (3) @(negedge clk);
        check("s0_hold_addr", bus.address, 4);

        // Song 1 with song_sel changed mid-song.
        for (int a = 1; a <= 6; a++) push_beat(a, 1'b1, (a == 1) ? 0 : 4);
        push_done(6, 1'b1);
        pulse_play(1'b1);
        check("s1_start_id", bus.song_id, 1);
        repeat (10) @(negedge clk);
        bus.song_sel = 1'b0;
        wait_done(40, n);
        check("s1_done_cycles", n, 18);
        check("s1_done_id", bus.song_id, 1);

        // Pause at tick 2 of address 3, resume about 10 cycles later.
        for (int a = 1; a <= 3; a++) push_beat(a, 1'b0, (a == 1) ? 0 : 4);
        push_beat(4, 1'b0, 0);
        push_done(4, 1'b0);
        pulse_play(1'b0);
        repeat (14) @(negedge clk);
        pulse_pause();
        check("pause_mute", bus.mute, 1);
        for (int i = 0; i < 9; i++) begin
            check("pause_hold_addr", bus.address, 3);
            @(negedge clk);
        end
        pulse_pause();
        check("resume_mute", bus.mute, 0);
        check("resume_addr0", bus.address, 3);
        @(negedge clk);
        check("resume_addr1", bus.address, 3);
        @(negedge clk);
        check("resume_addr2", bus.address, 4);
        wait_done(20, n);
        check("pause_done_cycles", n, 4);

        // stop+play together in PLAY: stop wins, play must not relatch song_sel.
        push_beat(1, 1'b1, 0);
        push_beat(2, 1'b1, 4);
        pulse_play(1'b1);
        repeat (9) @(negedge clk);
        bus.song_sel = 1'b0;
        bus.stop = 1'b1;
        bus.play = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        bus.play = 1'b0;
        check("stop_addr", bus.address, 0);
        check("stop_mute", bus.mute, 1);
        check("stop_done", bus.done, 0);
        check("stop_song_id", bus.song_id, 1);
        repeat (6) @(negedge clk);
        check("stop_idle_addr", bus.address, 0);
        for (int a = 1; a <= 4; a++) push_beat(a, 1'b0, (a == 1) ? 0 : 4);
        push_done(4, 1'b0);
        pulse_play(1'b0);
        check("restart_addr", bus.address, 0);
        check("restart_mute", bus.mute, 0);
        wait_done(40, n);
        check("restart_done_cycles", n, 20);

        // Reset pulse at address 2 in PLAY.
        push_beat(1, 1'b1, 0);
        push_beat(2, 1'b1, 4);
        pulse_play(1'b1);
        repeat (9) @(negedge clk);
        check("prerst_addr", bus.address, 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_address", bus.address, 0);
        check("mid_rst_song_id", bus.song_id, 0);
        check("mid_rst_beat", bus.beat_stb, 0);
        check("mid_rst_mute", bus.mute, 1);
        check("mid_rst_done", bus.done, 0);
        repeat (12) @(negedge clk);
        check("post_rst_done", bus.done, 0);
        check("post_rst_addr", bus.address, 0);
`endif

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
